nibble_serial_sum_ctrl: RTL and testbench
=========================================

Name: nibble_serial_sum_ctrl

Overview:
Sequencer that computes modular multi-operand sums using one 4-bit ripple-carry adder slice, one nibble per cycle. It replaces a full-width adder tree in area-constrained SHA-256 round logic, for example T1 = h + Σ1 + Ch + K + W.
- Operands arrive one per valid/ready handshake.
- A group ends with a last flag.
- The WIDTH-bit sum mod 2^WIDTH is presented on a valid/ready output.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4.
NIBBLES, WIDTH/4, derived nibble count; local, not overridable.

Ports:
i_clk  input  1  clock; all logic is on the rising edge.
i_rst  input  1  reset; one clock; reset is synchronous and active-high.
i_op_valid  input  1  operand present.
o_op_ready  output  1  block accepts an operand this cycle.
i_op_data  input  WIDTH  operand value.
i_op_last  input  1  operand is the final one of its group.
o_sum_valid  output  1  result available.
i_sum_ready  input  1  consumer takes the result.
o_sum  output  WIDTH  group sum mod 2^WIDTH.
o_overflow  output  1  at least one carry-out of the MSB nibble was discarded in this group.

Behaviour:
- Reset: state IDLE; accumulator, operand register, nibble counter, carry register and overflow flag all cleared.
  - Reset values: o_op_ready=0, o_sum_valid=0, o_sum=0, o_overflow=0.
  - o_op_ready rises the cycle after i_rst deasserts.
  - Reset mid-operation abandons the group. No partial result is ever emitted.
- State IDLE (no group open): o_op_ready=1.
  - Accept (valid&&ready) loads i_op_data directly into the accumulator. No add is performed; overflow is cleared.
  - Next state: DONE if i_op_last, else WAIT.
- State WAIT (partial sum held): o_op_ready=1.
  - Accept latches the operand and its last flag, clears the carry register and nibble counter, then goes to ADD.
  - With i_op_valid low, WAIT holds indefinitely.
- State ADD: o_op_ready=0. Runs for exactly NIBBLES cycles, counter k = 0..NIBBLES-1.
  - Each cycle: acc[4k+3:4k] <= slice sum of acc nibble k, operand nibble k and the carry register; the carry register <= slice carry-out.
  - On k = NIBBLES-1: if carry-out = 1, set overflow (sticky within the group).
  - Then go to DONE if the latched last flag is set, else WAIT.
- State DONE: o_sum_valid=1, o_sum=acc, o_overflow=flag. Outputs stay stable while i_sum_ready=0.
  - o_op_ready=0; i_op_valid is ignored.
  - On i_sum_ready, go to IDLE. o_op_ready=1 the next cycle.
- Latency (accept at edge t):
  - First operand with last set: o_sum_valid at t+1.
  - Non-first operand: ADD spans t+1..t+NIBBLES; WAIT or DONE is entered at t+NIBBLES+1.
  - Throughput: one added operand per NIBBLES+1 cycles. A group of N operands needs (N-1)*(NIBBLES+1)+1 cycles from the first accept to o_sum_valid, plus any input stalls.
- i_op_data is sampled only on the accept edge. Changes during ADD have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Carries never propagate between separate adds.
- All outputs are registered. There is no combinational path from i_sum_ready or i_op_valid to any output.

Decomposition:
- Shared adders package: state encoding (IDLE, WAIT, ADD, DONE as a 2-bit enum) and the constant NIBBLE_W = 4.
- One sub-module: the existing four_bit_RCA cell, instantiated once as the nibble slice.
  - Nibble muxing, carry register and counter stay in this controller.

Test Plan:
1. Single operand 0x12345678 with last -> o_sum_valid one cycle after accept; o_sum=0x12345678; o_overflow=0.
2. 0x0000000F then 0x00000001 (last) -> o_sum=0x00000010 at accept+9; the carry crosses the nibble 0/1 boundary; o_overflow=0.
3. 0xFFFFFFFF then 0x00000001 (last) -> o_sum=0x00000000; o_overflow=1. A following group 0x1 + 0x1 -> o_sum=0x2 with o_overflow=0 (flag cleared).
4. Five operands 0x6A09E667, 0xBB67AE85, 0x3C6EF372, 0xA54FF53A, 0x510E527F (last) -> o_sum=0x583ED017; o_overflow=1; o_sum_valid exactly 37 cycles after the first accept with no input stalls.
5. Backpressure: hold i_sum_ready=0 for 5 cycles in DONE while driving i_op_valid=1 -> o_sum is stable, o_op_ready=0, no operand is consumed. The accept happens the cycle after o_op_ready returns to 1.
6. Assert i_rst during ADD at k=3 -> next cycle all outputs 0 and state IDLE. Then 0x00000002 + 0x00000003 -> o_sum=0x00000005.

Source files
------------

// File: rtl/nibble_serial_sum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_sum_ctrl_pkg
// Description : Shared state encoding and slice width for the nibble-serial
//               multi-operand summing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_sum_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_sum_ctrl_rca.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_sum_ctrl_rca
// Description : Four-bit ripple-carry adder cell used as the nibble slice.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_sum_ctrl_rca (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_c[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_sum_ctrl
// Description : Modular multi-operand summer using one 4-bit adder slice,
//               processing one nibble per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_sum_ctrl
    import nibble_serial_sum_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [WIDTH-1:0] i_op_data,
    input  logic             i_op_last,
    output logic             o_sum_valid,
    input  logic             i_sum_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] c_last_nib = CNT_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_opd;
    logic               r_last;
    logic [CNT_W-1:0]   r_nib;
    logic               r_carry;
    logic               r_ovf;
    logic               r_op_ready;
    logic               r_sum_valid;

    logic               w_accept;
    logic               w_last_nib;
    int                 w_base;
    logic [NIBBLE_W-1:0] w_acc_nib;
    logic [NIBBLE_W-1:0] w_opd_nib;
    logic [NIBBLE_W-1:0] w_slice_sum;
    logic               w_slice_cout;

    assign w_accept   = i_op_valid & r_op_ready;
    assign w_last_nib = (r_nib == c_last_nib);
    assign w_base     = NIBBLE_W * int'(r_nib);
    assign w_acc_nib  = r_acc[w_base +: NIBBLE_W];
    assign w_opd_nib  = r_opd[w_base +: NIBBLE_W];

    nibble_serial_sum_ctrl_rca u_slice (
        .i_a    (w_acc_nib),
        .i_b    (w_opd_nib),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = i_op_last ? ST_DONE : ST_WAIT;
            ST_WAIT: if (w_accept) w_state_next = ST_ADD;
            ST_ADD:  if (w_last_nib) w_state_next = r_last ? ST_DONE : ST_WAIT;
            ST_DONE: if (i_sum_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so no input reaches them combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_ready  <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            r_op_ready  <= (w_state_next == ST_IDLE) || (w_state_next == ST_WAIT);
            r_sum_valid <= (w_state_next == ST_DONE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_opd   <= '0;
            r_last  <= 1'b0;
            r_nib   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc <= i_op_data;
                        r_ovf <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_accept) begin
                        r_opd   <= i_op_data;
                        r_last  <= i_op_last;
                        r_carry <= 1'b0;
                        r_nib   <= '0;
                    end
                end
                ST_ADD: begin
                    r_acc[w_base +: NIBBLE_W] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    r_nib   <= r_nib + 1'b1;
                    if (w_last_nib && w_slice_cout) begin
                        r_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_op_ready  = r_op_ready;
    assign o_sum_valid = r_sum_valid;
    assign o_sum       = r_acc;
    assign o_overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_sum_ctrl
// Description : Self-checking bench for nibble_serial_sum_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_sum_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_data;
    logic        op_last;
    logic        sum_valid;
    logic        sum_ready;
    logic [31:0] sum;
    logic        overflow;

    int checks;
    int failures;
    int cyc;

    typedef struct packed {
        logic [4:0][31:0] ops;
        logic [2:0]       n;
        logic [31:0]      exp_sum;
        logic             exp_ovf;
        logic [7:0]       exp_lat;
    } vec_t;

    vec_t vecs [7];

    nibble_serial_sum_ctrl #(.WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_op_valid  (op_valid),
        .o_op_ready  (op_ready),
        .i_op_data   (op_data),
        .i_op_last   (op_last),
        .o_sum_valid (sum_valid),
        .i_sum_ready (sum_ready),
        .o_sum       (sum),
        .o_overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [31:0] e,
                           input int n, input logic [31:0] s, input logic ovf, input int lat);
        vecs[idx].ops[0]  = a;
        vecs[idx].ops[1]  = b;
        vecs[idx].ops[2]  = c;
        vecs[idx].ops[3]  = d;
        vecs[idx].ops[4]  = e;
        vecs[idx].n       = 3'(n);
        vecs[idx].exp_sum = s;
        vecs[idx].exp_ovf = ovf;
        vecs[idx].exp_lat = 8'(lat);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge, valid still high.
    task automatic send(input logic [31:0] d, input logic last, output int acc_cyc);
        int waited;
        waited   = 0;
        op_valid = 1'b1;
        op_data  = d;
        op_last  = last;
        while (!op_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            chk("accept_timeout", 32'(op_ready), 32'd1);
        end
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic wait_valid(output int seen_cyc);
        int waited;
        waited = 0;
        while (!sum_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!sum_valid) chk("sum_valid_timeout", 32'(sum_valid), 32'd1);
        seen_cyc = cyc;
    endtask

    task automatic run_vec(input int idx);
        int first_cyc;
        int tmp;
        int seen;
        for (int i = 0; i < int'(vecs[idx].n); i++) begin
            send(vecs[idx].ops[i], (i == int'(vecs[idx].n) - 1), tmp);
            if (i == 0) first_cyc = tmp;
        end
        op_valid = 1'b0;
        wait_valid(seen);
        chk($sformatf("v%0d_sum", idx), sum, vecs[idx].exp_sum);
        chk($sformatf("v%0d_ovf", idx), 32'(overflow), 32'(vecs[idx].exp_ovf));
        chk($sformatf("v%0d_latency", idx), 32'(seen - first_cyc + 1), 32'(vecs[idx].exp_lat));
        chk($sformatf("v%0d_ready_in_done", idx), 32'(op_ready), 32'd0);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        chk($sformatf("v%0d_valid_drop", idx), 32'(sum_valid), 32'd0);
        chk($sformatf("v%0d_ready_back", idx), 32'(op_ready), 32'd1);
    endtask

    initial begin
        int tmp;
        int seen;
        logic [31:0] held;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        op_valid  = 1'b0;
        op_data   = '0;
        op_last   = 1'b0;
        sum_ready = 1'b0;

        set_vec(0, 32'h12345678, 0, 0, 0, 0, 1, 32'h12345678, 1'b0, 1);
        set_vec(1, 32'h0000000F, 32'h00000001, 0, 0, 0, 2, 32'h00000010, 1'b0, 10);
        set_vec(2, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 2, 32'h00000000, 1'b1, 10);
        set_vec(3, 32'h00000001, 32'h00000001, 0, 0, 0, 2, 32'h00000002, 1'b0, 10);
        set_vec(4, 32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A, 32'h510E527F,
                5, 32'h583ED017, 1'b1, 37);
        set_vec(5, 32'h11111111, 32'h22222222, 32'h33333333, 0, 0, 3, 32'h66666666, 1'b0, 19);
        set_vec(6, 32'h80000000, 32'h80000000, 0, 0, 0, 2, 32'h00000000, 1'b1, 10);

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(op_ready), 32'd0);
        chk("rst_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(op_ready), 32'd1);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Backpressure: DONE holds while the consumer stalls and operands are refused.
        send(32'h00000005, 1'b0, tmp);
        send(32'h00000006, 1'b1, tmp);
        op_valid = 1'b1;
        op_data  = 32'h00000100;
        op_last  = 1'b1;
        wait_valid(seen);
        held = sum;
        chk("bp_sum", held, 32'h0000000B);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_sum_stable", sum, 32'h0000000B);
            chk("bp_ready_low", 32'(op_ready), 32'd0);
            chk("bp_valid_held", 32'(sum_valid), 32'd1);
        end
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        chk("bp_ready_return", 32'(op_ready), 32'd1);
        chk("bp_no_early_accept", 32'(sum_valid), 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        chk("bp_accept_valid", 32'(sum_valid), 32'd1);
        chk("bp_accept_sum", sum, 32'h00000100);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;

        // Reset in the middle of ADD abandons the group.
        send(32'h12345678, 1'b0, tmp);
        send(32'h11111111, 1'b1, tmp);
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(op_ready), 32'd0);
        chk("midrst_valid", 32'(sum_valid), 32'd0);
        chk("midrst_sum", sum, 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_back", 32'(op_ready), 32'd1);
        set_vec(0, 32'h00000002, 32'h00000003, 0, 0, 0, 2, 32'h00000005, 1'b0, 10);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
